vproc_vreg_wr_arb: RTL and testbench
====================================

VPROC_VREG_WR_ARB -- requirements
Module: vproc_vreg_wr_arb

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- VREG_W, 128: vector register width in bits.
- PIPE_CNT, 2: number of requesting pipelines.
- VPORT_WR_CNT, 1: number of register-file write ports.
- PIPE_VPORT_WR[PIPE_CNT], '{0,0}: write port index per pipe.
- PIPE_CLR_BULK, '0: per-pipe bit; 1 selects group clear.
- DONT_CARE_ZERO, 0: drive don't-care outputs to zero instead of X.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk_i, in, 1: clock.
- sync_rst_ni, in, 1: reset; one clock domain, synchronous, active-low.
- vreg_wr_valid_i, in, PIPE_CNT: write request.
- vreg_wr_ready_o, out, PIPE_CNT: grant; combinational.
- vreg_wr_addr_i, in, PIPE_CNT x 5: destination vreg.
- vreg_wr_be_i, in, PIPE_CNT x VREG_W/8: byte enables.
- vreg_wr_data_i, in, PIPE_CNT x VREG_W: write data.
- vreg_wr_clr_i, in, PIPE_CNT: last write of an instruction; clear pending.
- vreg_wr_clr_cnt_i, in, PIPE_CNT x 2: log2 of the bulk-clear group size.
- pend_set_i, in, 32: dispatcher marks vregs pending.
- pend_vreg_wr_o, out, 32: pending-write scoreboard.
- vregfile_wr_en_o, out, VPORT_WR_CNT: registered write enable.
- vregfile_wr_addr_o, out, VPORT_WR_CNT x 5: registered write address.
- vregfile_wr_be_o, out, VPORT_WR_CNT x VREG_W/8: registered byte enables.
- vregfile_wr_data_o, out, VPORT_WR_CNT x VREG_W: registered write data.

Function
REQ-003 Each write port SHALL arbitrate only the pipes mapped to it through PIPE_VPORT_WR.
REQ-004 Each port SHALL use round-robin arbitration with a last-grant pointer: search starts at pointer+1 and wraps modulo PIPE_CNT.
REQ-005 At most one pipe per port SHALL be granted per cycle.
REQ-006 vreg_wr_ready_o[p] SHALL be high only when pipe p is valid and granted, or when pipe p is idle (valid low).
REQ-007 The pointer SHALL update to the granted pipe only on a grant; with no grant it holds.
REQ-008 A grant in cycle N SHALL appear on vregfile_wr_* in cycle N+1, so write latency is exactly 1 cycle.
REQ-009 With no grant, vregfile_wr_en_o SHALL be 0; addr/be/data SHALL be 0 if DONT_CARE_ZERO, otherwise X.
REQ-010 A granted write with clr=1 SHALL clear pending bits at the end of cycle N+1, i.e. visible from N+2, after the register file has committed.
REQ-011 Clear scope when PIPE_CLR_BULK[p]=0: only bit addr.
REQ-012 Clear scope when PIPE_CLR_BULK[p]=1: every bit j with (j & mask) == (addr & mask), where mask = 5'b11111 << clr_cnt; the group is aligned and has 1<<clr_cnt members.
REQ-013 Clears from several ports in the same cycle SHALL be ORed.
REQ-014 Next scoreboard state SHALL be (pend & ~clr) | pend_set_i, so set wins on a simultaneous set and clear of the same bit.
REQ-015 pend_vreg_wr_o SHALL be driven directly from the scoreboard register.
REQ-016 A port with a single mapped pipe SHALL grant that pipe whenever it is valid.

Reset
REQ-017 While sync_rst_ni=0 at a clock edge, the block SHALL reset as follows:
- vregfile_wr_en_o = 0.
- Registered addr/be/data = 0.
- All round-robin pointers = PIPE_CNT-1, so pipe 0 wins first.
- pend_vreg_wr_o = 0.
REQ-018 vreg_wr_ready_o SHALL be 0 during reset.
REQ-019 A write captured in the cycle before reset asserts SHALL be discarded, with no register-file write after reset.

Structure
REQ-020 The vreg address width constant (5) and the pending-clear count width (2) SHALL live in vproc_pkg.
REQ-021 Arbitration SHALL be one sub-module per port, vproc_rr_arb, parameterised by requester count and holding its own pointer.

Verification
REQ-022 Scenario 1: pipes 0 and 1 both on port 0, both valid continuously for 4 cycles -> grants 0,1,0,1 and wr_en high in cycles 2-5.
REQ-023 Scenario 2: pipe 1 alone writes addr 7 with be=all-ones and data=0xA5 repeated -> wr_en=1, addr=7, data=0xA5.. one cycle later; pipe 0 ready=1 while idle.
REQ-024 Scenario 3: pend_set_i=0x0000_00F0 then a bulk pipe writes clr=1, addr=5, clr_cnt=2 -> pend_vreg_wr_o=0 two cycles after the grant.
REQ-025 Scenario 4: pend_set_i bit 3 in the same cycle that bit 3's clear takes effect -> bit 3 remains 1.
REQ-026 Scenario 5: VPORT_WR_CNT=2 with pipe 0 on port 0 and pipe 1 on port 1, both valid -> both ready, both wr_en asserted in the same cycle.
REQ-027 Scenario 6: sync_rst_ni low in the cycle after a grant -> wr_en=0, pend=0, and the next grant goes to pipe 0.

Source files
------------

// File: rtl/vproc_pkg.sv
// vproc_pkg: shared vreg address/clear-count widths and pending-clear mask helper
package vproc_pkg;
  localparam int unsigned VREG_ADDR_W = 5;
  localparam int unsigned CLR_CNT_W = 2;
  function automatic logic [31:0] pend_clr_mask(
    input logic [VREG_ADDR_W-1:0] addr,
    input logic [CLR_CNT_W-1:0] cnt,
    input logic bulk
  );
    logic [VREG_ADDR_W-1:0] m;
    logic [31:0] r;
    m = bulk ? {VREG_ADDR_W{1'b1}} << cnt : {VREG_ADDR_W{1'b1}};
    for (int j = 0; j < 32; j++) r[j] = (VREG_ADDR_W'(j) & m) == (addr & m);
    return r;
  endfunction
endpackage

// File: rtl/vproc_vreg_wr_arb_if.sv
// vproc_vreg_wr_arb_if: pipeline write requests, register-file write ports and pending scoreboard
interface vproc_vreg_wr_arb_if #(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned PIPE_CNT = 2,
  parameter int unsigned VPORT_WR_CNT = 1
);
  import vproc_pkg::*;
  logic [PIPE_CNT-1:0] vreg_wr_valid_i;
  logic [PIPE_CNT-1:0] vreg_wr_ready_o;
  logic [PIPE_CNT-1:0][VREG_ADDR_W-1:0] vreg_wr_addr_i;
  logic [PIPE_CNT-1:0][VREG_W/8-1:0] vreg_wr_be_i;
  logic [PIPE_CNT-1:0][VREG_W-1:0] vreg_wr_data_i;
  logic [PIPE_CNT-1:0] vreg_wr_clr_i;
  logic [PIPE_CNT-1:0][CLR_CNT_W-1:0] vreg_wr_clr_cnt_i;
  logic [31:0] pend_set_i;
  logic [31:0] pend_vreg_wr_o;
  logic [VPORT_WR_CNT-1:0] vregfile_wr_en_o;
  logic [VPORT_WR_CNT-1:0][VREG_ADDR_W-1:0] vregfile_wr_addr_o;
  logic [VPORT_WR_CNT-1:0][VREG_W/8-1:0] vregfile_wr_be_o;
  logic [VPORT_WR_CNT-1:0][VREG_W-1:0] vregfile_wr_data_o;
  modport master (
    output vreg_wr_valid_i, vreg_wr_addr_i, vreg_wr_be_i, vreg_wr_data_i,
    output vreg_wr_clr_i, vreg_wr_clr_cnt_i, pend_set_i,
    input vreg_wr_ready_o, pend_vreg_wr_o,
    input vregfile_wr_en_o, vregfile_wr_addr_o, vregfile_wr_be_o, vregfile_wr_data_o
  );
  modport slave (
    input vreg_wr_valid_i, vreg_wr_addr_i, vreg_wr_be_i, vreg_wr_data_i,
    input vreg_wr_clr_i, vreg_wr_clr_cnt_i, pend_set_i,
    output vreg_wr_ready_o, pend_vreg_wr_o,
    output vregfile_wr_en_o, vregfile_wr_addr_o, vregfile_wr_be_o, vregfile_wr_data_o
  );
endinterface

// File: rtl/vproc_rr_arb.sv
// vproc_rr_arb: round-robin arbiter whose search starts just after the last granted requester
module vproc_rr_arb #(
  parameter int unsigned N = 2
) (
  input logic clk_i,
  input logic sync_rst_ni,
  input logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);
  localparam int unsigned PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr_d, ptr_q;
  int idx;
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx = 0;
    for (int k = N; k > 0; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (req_i[idx]) begin
        gnt_o = '0;
        gnt_o[idx] = 1'b1;
        ptr_d = PW'(idx);
      end
    end
  end
  always_ff @(posedge clk_i) ptr_q <= !sync_rst_ni ? PW'(N - 1) : ptr_d;
endmodule

// File: rtl/vproc_vreg_wr_arb.sv
// vproc_vreg_wr_arb: arbitrates pipeline vreg writes onto register-file write ports and tracks pending writes
module vproc_vreg_wr_arb import vproc_pkg::*; #(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned PIPE_CNT = 2,
  parameter int unsigned VPORT_WR_CNT = 1,
  parameter int unsigned PIPE_VPORT_WR [PIPE_CNT] = '{0, 0},
  parameter logic [PIPE_CNT-1:0] PIPE_CLR_BULK = '0,
  parameter bit DONT_CARE_ZERO = 1'b0
) (
  input logic clk_i,
  input logic sync_rst_ni,
  vproc_vreg_wr_arb_if.slave bus
);
  logic [VPORT_WR_CNT-1:0][PIPE_CNT-1:0] gnt;
  logic [PIPE_CNT-1:0] pipe_gnt;
  logic [VPORT_WR_CNT-1:0] wr_en_d, wr_en_q;
  logic [VPORT_WR_CNT-1:0][VREG_ADDR_W-1:0] wr_addr_d, wr_addr_q;
  logic [VPORT_WR_CNT-1:0][VREG_W/8-1:0] wr_be_d, wr_be_q;
  logic [VPORT_WR_CNT-1:0][VREG_W-1:0] wr_data_d, wr_data_q;
  logic [31:0] clr_d, clr_q, pend_d, pend_q;
  for (genvar p = 0; p < VPORT_WR_CNT; p++) begin : g_port
    logic [PIPE_CNT-1:0] req;
    for (genvar i = 0; i < PIPE_CNT; i++) begin : g_req
      assign req[i] = bus.vreg_wr_valid_i[i] && PIPE_VPORT_WR[i] == p;
    end
    vproc_rr_arb #(.N(PIPE_CNT)) u_arb (
      .clk_i(clk_i),
      .sync_rst_ni(sync_rst_ni),
      .req_i(req),
      .gnt_o(gnt[p])
    );
  end
  always_comb begin
    pipe_gnt = '0;
    wr_en_d = '0;
    wr_addr_d = DONT_CARE_ZERO ? '0 : 'x;
    wr_be_d = DONT_CARE_ZERO ? '0 : 'x;
    wr_data_d = DONT_CARE_ZERO ? '0 : 'x;
    clr_d = '0;
    for (int p = 0; p < VPORT_WR_CNT; p++) begin
      for (int i = 0; i < PIPE_CNT; i++) begin
        if (gnt[p][i]) begin
          pipe_gnt[i] = 1'b1;
          wr_en_d[p] = 1'b1;
          wr_addr_d[p] = bus.vreg_wr_addr_i[i];
          wr_be_d[p] = bus.vreg_wr_be_i[i];
          wr_data_d[p] = bus.vreg_wr_data_i[i];
          if (bus.vreg_wr_clr_i[i])
            clr_d |= pend_clr_mask(bus.vreg_wr_addr_i[i], bus.vreg_wr_clr_cnt_i[i], PIPE_CLR_BULK[i]);
        end
      end
    end
    pend_d = (pend_q & ~clr_q) | bus.pend_set_i;
  end
  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      wr_en_q <= '0;
      wr_addr_q <= '0;
      wr_be_q <= '0;
      wr_data_q <= '0;
      clr_q <= '0;
      pend_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_be_q <= wr_be_d;
      wr_data_q <= wr_data_d;
      clr_q <= clr_d;
      pend_q <= pend_d;
    end
  end
  assign bus.vreg_wr_ready_o = {PIPE_CNT{sync_rst_ni}} & (~bus.vreg_wr_valid_i | pipe_gnt);
  assign bus.vregfile_wr_en_o = wr_en_q & {VPORT_WR_CNT{sync_rst_ni}};
  assign bus.vregfile_wr_addr_o = wr_addr_q;
  assign bus.vregfile_wr_be_o = wr_be_q;
  assign bus.vregfile_wr_data_o = wr_data_q;
  assign bus.pend_vreg_wr_o = pend_q;
endmodule

// File: tb/tb_vproc_vreg_wr_arb.sv
// tb_vproc_vreg_wr_arb: table-driven check of arbitration, write latency, scoreboard and reset
module tb_vproc_vreg_wr_arb;
  localparam logic [127:0] D0 = {16{8'h3C}};
  localparam logic [127:0] D1 = {16{8'hA5}};
  localparam logic [15:0] BE0 = 16'h0F0F;
  localparam logic [15:0] BE1 = 16'hFFFF;
  typedef struct {
    logic rst_n;
    logic [1:0] valid;
    logic [4:0] a0;
    logic [4:0] a1;
    logic [1:0] clr;
    logic [1:0] cnt1;
    logic [31:0] set;
    logic [1:0] exp_rdy;
    logic exp_en;
    logic [4:0] exp_addr;
    int exp_src;
    logic [31:0] exp_pend;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  vec_t vec [20];
  always #5 clk = ~clk;
  vproc_vreg_wr_arb_if #(.VREG_W(128), .PIPE_CNT(2), .VPORT_WR_CNT(1)) busa ();
  vproc_vreg_wr_arb_if #(.VREG_W(128), .PIPE_CNT(2), .VPORT_WR_CNT(2)) busb ();
  vproc_vreg_wr_arb #(
    .VREG_W(128), .PIPE_CNT(2), .VPORT_WR_CNT(1), .PIPE_VPORT_WR('{0, 0}),
    .PIPE_CLR_BULK(2'b10), .DONT_CARE_ZERO(1'b1)
  ) dut_a (
    .clk_i(clk),
    .sync_rst_ni(rst_n),
    .bus(busa)
  );
  vproc_vreg_wr_arb #(
    .VREG_W(128), .PIPE_CNT(2), .VPORT_WR_CNT(2), .PIPE_VPORT_WR('{0, 1}),
    .PIPE_CLR_BULK(2'b00), .DONT_CARE_ZERO(1'b1)
  ) dut_b (
    .clk_i(clk),
    .sync_rst_ni(rst_n),
    .bus(busb)
  );
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  initial begin
    vec[0]  = '{1'b0, 2'b11, 5'd1, 5'd2,  2'b00, 2'd0, 32'h00, 2'b00, 1'b0, 5'd0,  -1, 32'h00};
    vec[1]  = '{1'b1, 2'b11, 5'd1, 5'd2,  2'b00, 2'd0, 32'h00, 2'b01, 1'b0, 5'd0,  -1, 32'h00};
    vec[2]  = '{1'b1, 2'b11, 5'd1, 5'd2,  2'b00, 2'd0, 32'h00, 2'b10, 1'b1, 5'd1,   0, 32'h00};
    vec[3]  = '{1'b1, 2'b11, 5'd1, 5'd2,  2'b00, 2'd0, 32'h00, 2'b01, 1'b1, 5'd2,   1, 32'h00};
    vec[4]  = '{1'b1, 2'b11, 5'd1, 5'd2,  2'b00, 2'd0, 32'h00, 2'b10, 1'b1, 5'd1,   0, 32'h00};
    vec[5]  = '{1'b1, 2'b00, 5'd1, 5'd2,  2'b00, 2'd0, 32'h00, 2'b11, 1'b1, 5'd2,   1, 32'h00};
    vec[6]  = '{1'b1, 2'b10, 5'd1, 5'd7,  2'b00, 2'd0, 32'h00, 2'b11, 1'b0, 5'd0,  -1, 32'h00};
    vec[7]  = '{1'b1, 2'b00, 5'd1, 5'd7,  2'b00, 2'd0, 32'h00, 2'b11, 1'b1, 5'd7,   1, 32'h00};
    vec[8]  = '{1'b1, 2'b00, 5'd0, 5'd0,  2'b00, 2'd0, 32'hF0, 2'b11, 1'b0, 5'd0,  -1, 32'h00};
    vec[9]  = '{1'b1, 2'b10, 5'd0, 5'd5,  2'b10, 2'd2, 32'h00, 2'b11, 1'b0, 5'd0,  -1, 32'hF0};
    vec[10] = '{1'b1, 2'b00, 5'd0, 5'd5,  2'b00, 2'd0, 32'h00, 2'b11, 1'b1, 5'd5,   1, 32'hF0};
    vec[11] = '{1'b1, 2'b00, 5'd0, 5'd0,  2'b00, 2'd0, 32'h0C, 2'b11, 1'b0, 5'd0,  -1, 32'h00};
    vec[12] = '{1'b1, 2'b01, 5'd3, 5'd0,  2'b01, 2'd0, 32'h00, 2'b11, 1'b0, 5'd0,  -1, 32'h0C};
    vec[13] = '{1'b1, 2'b00, 5'd3, 5'd0,  2'b00, 2'd0, 32'h08, 2'b11, 1'b1, 5'd3,   0, 32'h0C};
    vec[14] = '{1'b1, 2'b01, 5'd2, 5'd0,  2'b01, 2'd0, 32'h00, 2'b11, 1'b0, 5'd0,  -1, 32'h0C};
    vec[15] = '{1'b1, 2'b00, 5'd2, 5'd0,  2'b00, 2'd0, 32'h00, 2'b11, 1'b1, 5'd2,   0, 32'h0C};
    vec[16] = '{1'b1, 2'b11, 5'd9, 5'd10, 2'b00, 2'd0, 32'h00, 2'b10, 1'b0, 5'd0,  -1, 32'h08};
    vec[17] = '{1'b0, 2'b00, 5'd9, 5'd10, 2'b00, 2'd0, 32'h00, 2'b00, 1'b0, 5'd10,  1, 32'h08};
    vec[18] = '{1'b1, 2'b11, 5'd9, 5'd10, 2'b00, 2'd0, 32'h00, 2'b01, 1'b0, 5'd0,  -1, 32'h00};
    vec[19] = '{1'b1, 2'b00, 5'd9, 5'd10, 2'b00, 2'd0, 32'h00, 2'b11, 1'b1, 5'd9,   0, 32'h00};
    busa.vreg_wr_valid_i = '0;
    busa.vreg_wr_addr_i = '0;
    busa.vreg_wr_be_i = {BE1, BE0};
    busa.vreg_wr_data_i = {D1, D0};
    busa.vreg_wr_clr_i = '0;
    busa.vreg_wr_clr_cnt_i = {2'd0, 2'd3};
    busa.pend_set_i = '0;
    busb.vreg_wr_valid_i = '0;
    busb.vreg_wr_addr_i = '0;
    busb.vreg_wr_be_i = {BE1, BE0};
    busb.vreg_wr_data_i = {D1, D0};
    busb.vreg_wr_clr_i = '0;
    busb.vreg_wr_clr_cnt_i = '0;
    busb.pend_set_i = '0;
    repeat (2) @(posedge clk);
    for (int r = 0; r < 20; r++) begin
      @(negedge clk);
      rst_n = vec[r].rst_n;
      busa.vreg_wr_valid_i = vec[r].valid;
      busa.vreg_wr_addr_i = {vec[r].a1, vec[r].a0};
      busa.vreg_wr_clr_i = vec[r].clr;
      busa.vreg_wr_clr_cnt_i = {vec[r].cnt1, 2'd3};
      busa.pend_set_i = vec[r].set;
      #1;
      chk($sformatf("r%0d_ready", r), 128'(busa.vreg_wr_ready_o), 128'(vec[r].exp_rdy));
      chk($sformatf("r%0d_wr_en", r), 128'(busa.vregfile_wr_en_o), 128'(vec[r].exp_en));
      chk($sformatf("r%0d_wr_addr", r), 128'(busa.vregfile_wr_addr_o), 128'(vec[r].exp_addr));
      chk($sformatf("r%0d_wr_be", r), 128'(busa.vregfile_wr_be_o),
          vec[r].exp_src < 0 ? 128'(0) : vec[r].exp_src == 0 ? 128'(BE0) : 128'(BE1));
      chk($sformatf("r%0d_wr_data", r), busa.vregfile_wr_data_o,
          vec[r].exp_src < 0 ? 128'(0) : vec[r].exp_src == 0 ? D0 : D1);
      chk($sformatf("r%0d_pend", r), 128'(busa.pend_vreg_wr_o), 128'(vec[r].exp_pend));
    end
    @(negedge clk);
    busa.vreg_wr_valid_i = '0;
    busb.vreg_wr_valid_i = 2'b11;
    busb.vreg_wr_addr_i = {5'd6, 5'd4};
    #1;
    chk("b_both_ready", 128'(busb.vreg_wr_ready_o), 128'(2'b11));
    chk("b_idle_en", 128'(busb.vregfile_wr_en_o), 128'(2'b00));
    @(negedge clk);
    busb.vreg_wr_valid_i = 2'b01;
    busb.vreg_wr_addr_i = {5'd6, 5'd8};
    #1;
    chk("b_both_en", 128'(busb.vregfile_wr_en_o), 128'(2'b11));
    chk("b_addr0", 128'(busb.vregfile_wr_addr_o[0]), 128'(5'd4));
    chk("b_addr1", 128'(busb.vregfile_wr_addr_o[1]), 128'(5'd6));
    chk("b_data0", busb.vregfile_wr_data_o[0], D0);
    chk("b_data1", busb.vregfile_wr_data_o[1], D1);
    chk("b_ready_single", 128'(busb.vreg_wr_ready_o), 128'(2'b11));
    @(negedge clk);
    busb.vreg_wr_valid_i = 2'b00;
    #1;
    chk("b_en_port0_only", 128'(busb.vregfile_wr_en_o), 128'(2'b01));
    chk("b_addr0_again", 128'(busb.vregfile_wr_addr_o[0]), 128'(5'd8));
    chk("b_pend", 128'(busb.pend_vreg_wr_o), 128'(0));
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
